// File: rtl/ysyx_22040228_clint.sv
// Core-local interruptor: mtime / mtimecmp / msip behind a single-outstanding
// request/response port, driving the machine timer and software interrupt levels.
module ysyx_22040228_clint #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tmr_intr_ena,
    output logic        sw_intr_ena
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
    localparam logic [15:0] DIV_LAST     = 16'(MTIME_DIV - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] mtime_reg;
    logic [63:0] mtimecmp_reg;
    logic        msip_reg;
    logic [15:0] presc_reg;
    logic        tmr_reg;
    logic        sw_reg;
    logic [63:0] rdata_reg, rdata_next;
    logic        err_reg;

    logic [63:0] wmask;
    logic        in_window;
    logic        sel_msip, sel_cmp, sel_mtime, addr_ok;
    logic        accept, do_write, wr_mtime, tick;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
        end
    endgenerate

    // Register offsets are 8-byte aligned, so a misaligned address simply
    // fails to match any of them and falls into the error path.
    assign in_window = (req_addr[63:16] == BASE_ADDR[63:16]);
    assign sel_msip  = in_window && (req_addr[15:0] == OFF_MSIP);
    assign sel_cmp   = in_window && (req_addr[15:0] == OFF_MTIMECMP);
    assign sel_mtime = in_window && (req_addr[15:0] == OFF_MTIME);
    assign addr_ok   = sel_msip | sel_cmp | sel_mtime;

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign accept    = req_valid & req_ready;
    assign do_write  = accept & req_wr & addr_ok;
    assign wr_mtime  = do_write & sel_mtime & (|req_wstrb);
    assign tick      = (presc_reg == DIV_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdata_next = 64'd0;
        if (!req_wr) begin
            if (sel_msip)  rdata_next = {63'd0, msip_reg};
            if (sel_cmp)   rdata_next = mtimecmp_reg;
            if (sel_mtime) rdata_next = mtime_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rdata_reg <= 64'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rdata_reg <= rdata_next;
                err_reg   <= ~addr_ok;
            end
        end
    end

    // A software write to mtime overrides a coincident tick and restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg <= 64'd0;
            presc_reg <= 16'd0;
        end else if (wr_mtime) begin
            mtime_reg <= (mtime_reg & ~wmask) | (req_wdata & wmask);
            presc_reg <= 16'd0;
        end else if (tick) begin
            mtime_reg <= mtime_reg + 64'd1;
            presc_reg <= 16'd0;
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_reg     <= 1'b0;
            tmr_reg      <= 1'b0;
            sw_reg       <= 1'b0;
        end else begin
            if (do_write && sel_cmp)
                mtimecmp_reg <= (mtimecmp_reg & ~wmask) | (req_wdata & wmask);
            if (do_write && sel_msip && req_wstrb[0])
                msip_reg <= req_wdata[0];
            tmr_reg <= (mtime_reg >= mtimecmp_reg);
            sw_reg  <= msip_reg;
        end
    end

    assign rsp_rdata    = rdata_reg;
    assign rsp_err      = err_reg;
    assign tmr_intr_ena = tmr_reg;
    assign sw_intr_ena  = sw_reg;

endmodule

// File: tb/tb_ysyx_22040228_clint.sv
// Bench for ysyx_22040228_clint: two instances (MTIME_DIV 1 and 4) share one bus
// and are compared against a time-based model of mtime, mtimecmp and msip.
module tb_ysyx_22040228_clint;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP = BASE;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_MT   = BASE + 64'hBFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic [7:0]  req_wstrb = 8'd0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_tmr, a_sw;
    logic [63:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_tmr, b_sw;
    logic [63:0] b_rsp_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22040228_clint #(.BASE_ADDR(BASE), .MTIME_DIV(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .tmr_intr_ena(a_tmr), .sw_intr_ena(a_sw)
    );

    ysyx_22040228_clint #(.BASE_ADDR(BASE), .MTIME_DIV(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .tmr_intr_ena(b_tmr), .sw_intr_ena(b_sw)
    );

    // Model: mtime after edge n is base + floor((n - t0) / div); one older
    // segment is kept so values just before the latest write stay answerable.
    logic [63:0] m_base[2], m_base_p[2];
    int          m_t0[2], m_t0_p[2];
    logic [63:0] m_cmp, m_cmp_p;
    int          m_cmp_t;
    logic        m_msip, m_msip_p;
    int          m_msip_t;

    function automatic int div_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [63:0] mt_after(int i, int n);
        longint k;
        if (n >= m_t0[i]) begin
            k = longint'((n - m_t0[i]) / div_of(i));
            return m_base[i] + 64'(k);
        end
        k = longint'((n - m_t0_p[i]) / div_of(i));
        return m_base_p[i] + 64'(k);
    endfunction

    function automatic logic [63:0] cmp_after(int n);
        return (n >= m_cmp_t) ? m_cmp : m_cmp_p;
    endfunction

    function automatic logic msip_after(int n);
        return (n >= m_msip_t) ? m_msip : m_msip_p;
    endfunction

    function automatic logic exp_tmr(int i, int n);
        return mt_after(i, n - 1) >= cmp_after(n - 1);
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] strb);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic int reg_of(logic [63:0] addr);
        if (addr[63:16] != BASE[63:16]) return -1;
        case (addr[15:0])
            16'h0000: return 0;
            16'h4000: return 1;
            16'hBFF8: return 2;
            default:  return -1;
        endcase
    endfunction

    function automatic logic [63:0] exp_read(int i, logic [63:0] addr, int e);
        case (reg_of(addr))
            0:       return {63'd0, msip_after(e - 1)};
            1:       return cmp_after(e - 1);
            2:       return mt_after(i, e - 1);
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset(input int r);
        for (int i = 0; i < 2; i++) begin
            m_base[i] = 64'd0; m_base_p[i] = 64'd0;
            m_t0[i] = r;       m_t0_p[i] = r;
        end
        m_cmp = ONES; m_cmp_p = ONES; m_cmp_t = r;
        m_msip = 1'b0; m_msip_p = 1'b0; m_msip_t = r;
    endtask

    task automatic model_write(input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] strb, input int e);
        logic [63:0] old;
        case (reg_of(addr))
            0: if (strb[0]) begin
                m_msip_p = msip_after(e - 1); m_msip = wdata[0]; m_msip_t = e;
            end
            1: begin
                old = cmp_after(e - 1);
                m_cmp_p = old; m_cmp = merge(old, wdata, strb); m_cmp_t = e;
            end
            2: if (strb != 8'd0) begin
                for (int i = 0; i < 2; i++) begin
                    old = mt_after(i, e - 1);
                    m_base_p[i] = m_base[i]; m_t0_p[i] = m_t0[i];
                    m_base[i] = merge(old, wdata, strb); m_t0[i] = e;
                end
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        step(); step();
        model_reset(cyc);
        rst = 1'b0;
    endtask

    // One full transaction; returns just after the response handshake edge.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] strb, output logic [63:0] rd_a, output logic [63:0] rd_b,
                          output logic er_a, output logic er_b, output int acc);
        int waitc;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        rsp_ready = 1'b1;
        step();
        acc = cyc;
        req_valid = 1'b0;
        if (wr) model_write(addr, wdata, strb, acc);
        waitc = 0;
        while (!(a_rsp_valid && b_rsp_valid) && waitc < 16) begin
            step();
            waitc++;
        end
        total++;
        if (waitc != 0) begin
            bad++;
            $display("FAIL rsp_latency addr=%h extra_cycles=%0d want=0", addr, waitc);
        end
        rd_a = a_rsp_rdata; rd_b = b_rsp_rdata; er_a = a_rsp_err; er_b = b_rsp_err;
        step();
        $display("txn wr=%0b addr=%h wdata=%h strb=%h acc=%0d rd_a=%h rd_b=%h err=%0b%0b",
                 wr, addr, wdata, strb, acc, rd_a, rd_b, er_a, er_b);
    endtask

    task automatic test_reset();
        logic [63:0] ra, rb;
        logic ea, eb;
        int acc;
        rst = 1'b1;
        step(); step();
        total++;
        if ({a_req_ready, a_rsp_valid, a_rsp_err, a_tmr, a_sw, b_req_ready, b_rsp_valid} !== 7'b1000010
            || a_rsp_rdata !== 64'd0 || b_rsp_rdata !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b rdata=%h want=1000010 rdata=0",
                     {a_req_ready, a_rsp_valid, a_rsp_err, a_tmr, a_sw, b_req_ready, b_rsp_valid}, a_rsp_rdata);
        end
        model_reset(cyc);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== exp_read(0, A_MT, acc) || ra !== 64'(acc - 1 - m_t0[0])) begin
            bad++;
            $display("FAIL reset_mtime_a got=%h want=%h", ra, exp_read(0, A_MT, acc));
        end
        total++;
        if (rb !== exp_read(1, A_MT, acc)) begin
            bad++;
            $display("FAIL reset_mtime_b got=%h want=%h", rb, exp_read(1, A_MT, acc));
        end
        total++;
        if (ea !== 1'b0 || a_tmr !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_flags got err=%0b tmr=%0b want 0 0", ea, a_tmr);
        end
    endtask

    task automatic test_cmp_irq();
        logic [63:0] ra, rb;
        logic ea, eb;
        int acc, r, rise;
        do_reset();
        r = cyc;
        step();
        do_req(1'b1, A_CMP, 64'd20, 8'hFF, ra, rb, ea, eb, acc);
        rise = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (a_tmr && rise < 0) rise = cyc;
            total++;
            if (a_tmr !== exp_tmr(0, cyc) || b_tmr !== exp_tmr(1, cyc)) begin
                bad++;
                $display("FAIL cmp_irq_level edge=%0d got=%0b%0b want=%0b%0b",
                         cyc, a_tmr, b_tmr, exp_tmr(0, cyc), exp_tmr(1, cyc));
            end
        end
        total++;
        if (rise != r + 21) begin
            bad++;
            $display("FAIL cmp_irq_rise_edge got=%0d want=%0d", rise, r + 21);
        end
        do_req(1'b1, A_CMP, ONES, 8'hFF, ra, rb, ea, eb, acc);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (a_tmr !== 1'b0 || a_tmr !== exp_tmr(0, cyc)) begin
                bad++;
                $display("FAIL cmp_irq_clear edge=%0d got=%0b want=0", cyc, a_tmr);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [63:0] ra, rb, x;
        logic ea, eb;
        int acc, e;
        do_reset();
        do_req(1'b1, A_MT, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, ra, rb, ea, eb, e);
        step(); step();
        do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (acc != e + 4 || ra !== 64'd1 || ra !== exp_read(0, A_MT, acc)) begin
            bad++;
            $display("FAIL wrap_read acc_off=%0d got=%h want=1", acc - e, ra);
        end
        total++;
        if (rb !== exp_read(1, A_MT, acc)) begin
            bad++;
            $display("FAIL wrap_read_b got=%h want=%h", rb, exp_read(1, A_MT, acc));
        end
        x = {$urandom, $urandom};
        do_req(1'b1, A_MT, x, 8'hFF, ra, rb, ea, eb, e);
        do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== x + 64'd1 || rb !== x) begin
            bad++;
            $display("FAIL write_on_tick got=%h/%h want=%h/%h", ra, rb, x + 64'd1, x);
        end
    endtask

    task automatic test_div4();
        logic [63:0] ra, rb, want;
        logic ea, eb;
        int acc, e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
            do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
            total++;
            if (rb !== exp_read(1, A_MT, acc) || ra !== exp_read(0, A_MT, acc)) begin
                bad++;
                $display("FAIL div4_count acc=%0d got=%h/%h want=%h/%h", acc, ra, rb,
                         exp_read(0, A_MT, acc), exp_read(1, A_MT, acc));
            end
        end
        for (int g = $urandom_range(0, 3); g > 0; g--) step();
        do_req(1'b1, A_MT, 64'd100, 8'hFF, ra, rb, ea, eb, e);
        for (int k = 0; k < 6; k++) begin
            do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
            want = 64'd100 + 64'((acc - 1 - e) / 4);
            total++;
            if (rb !== want) begin
                bad++;
                $display("FAIL div4_restart acc_off=%0d got=%h want=%h", acc - e, rb, want);
            end
        end
    endtask

    task automatic test_msip();
        logic [63:0] ra, rb;
        logic ea, eb;
        int acc;
        do_reset();
        do_req(1'b1, A_MSIP, ONES, 8'hFF, ra, rb, ea, eb, acc);
        total++;
        if (a_sw !== 1'b1 || b_sw !== 1'b1) begin
            bad++;
            $display("FAIL msip_sw_set got=%0b%0b want=11", a_sw, b_sw);
        end
        do_req(1'b0, A_MSIP, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== 64'd1) begin
            bad++;
            $display("FAIL msip_read_one got=%h want=1", ra);
        end
        do_req(1'b1, A_MSIP, 64'd0, 8'h02, ra, rb, ea, eb, acc);
        do_req(1'b0, A_MSIP, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== 64'd1 || a_sw !== 1'b1) begin
            bad++;
            $display("FAIL msip_strb_skip got=%h sw=%0b want=1 1", ra, a_sw);
        end
        do_req(1'b1, A_MSIP, 64'd0, 8'hFF, ra, rb, ea, eb, acc);
        do_req(1'b0, A_MSIP, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== 64'd0 || a_sw !== 1'b0) begin
            bad++;
            $display("FAIL msip_clear got=%h sw=%0b want=0 0", ra, a_sw);
        end
    endtask

    task automatic test_errors();
        logic [63:0] ra, rb, addr;
        logic ea, eb;
        int acc;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       addr = BASE + 64'h4;
                1:       addr = BASE + 64'h1000;
                2:       addr = BASE + 64'h1_0000;
                default: addr = 64'h0;
            endcase
            do_req(1'b0, addr, 64'd0, 8'h00, ra, rb, ea, eb, acc);
            total++;
            if (ea !== 1'b1 || eb !== 1'b1 || ra !== 64'd0) begin
                bad++;
                $display("FAIL err_read addr=%h got err=%0b%0b rdata=%h want 11 0", addr, ea, eb, ra);
            end
        end
        do_req(1'b1, BASE + 64'h4004, 64'd0, 8'hFF, ra, rb, ea, eb, acc);
        total++;
        if (ea !== 1'b1) begin
            bad++;
            $display("FAIL err_write got err=%0b want=1", ea);
        end
        do_req(1'b0, A_CMP, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== ONES || ea !== 1'b0) begin
            bad++;
            $display("FAIL err_no_change got=%h err=%0b want=%h 0", ra, ea, ONES);
        end
    endtask

    task automatic test_stall();
        logic [63:0] d0, ra, rb;
        logic e0, ea, eb;
        int acc;
        do_reset();
        step(); step();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = A_MT; req_wstrb = 8'h00; rsp_ready = 1'b0;
        step();
        acc = cyc;
        req_valid = 1'b0;
        d0 = a_rsp_rdata; e0 = a_rsp_err;
        total++;
        if (d0 !== exp_read(0, A_MT, acc)) begin
            bad++;
            $display("FAIL stall_data got=%h want=%h", d0, exp_read(0, A_MT, acc));
        end
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (a_req_ready !== 1'b0 || a_rsp_valid !== 1'b1 || a_rsp_rdata !== d0 || a_rsp_err !== e0) begin
                bad++;
                $display("FAIL stall_hold k=%0d got rdy=%0b vld=%0b data=%h want 0 1 %h",
                         k, a_req_ready, a_rsp_valid, a_rsp_rdata, d0);
            end
        end
        rsp_ready = 1'b1;
        step();
        total++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got vld=%0b rdy=%0b want 0 1", a_rsp_valid, a_req_ready);
        end
        do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== exp_read(0, A_MT, acc)) begin
            bad++;
            $display("FAIL stall_counting got=%h want=%h", ra, exp_read(0, A_MT, acc));
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] ra, rb;
        logic ea, eb;
        int acc;
        do_reset();
        do_req(1'b1, A_CMP, 64'd5, 8'hFF, ra, rb, ea, eb, acc);
        do_req(1'b1, A_MSIP, 64'd1, 8'h01, ra, rb, ea, eb, acc);
        for (int k = 0; k < 4; k++) step();
        total++;
        if (a_tmr !== 1'b1 || a_sw !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_irqs got=%0b%0b want=11", a_tmr, a_sw);
        end
        req_valid = 1'b1; req_wr = 1'b0; req_addr = A_MT; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        total++;
        if ({a_rsp_valid, a_req_ready, a_tmr, a_sw, a_rsp_err} !== 5'b01000 || a_rsp_rdata !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid got=%b rdata=%h want=01000 rdata=0",
                     {a_rsp_valid, a_req_ready, a_tmr, a_sw, a_rsp_err}, a_rsp_rdata);
        end
        model_reset(cyc);
        rst = 1'b0; rsp_ready = 1'b1;
        do_req(1'b0, A_CMP, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== ONES) begin
            bad++;
            $display("FAIL reset_mid_cmp got=%h want=%h", ra, ONES);
        end
        do_req(1'b0, A_MSIP, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid_msip got=%h want=0", ra);
        end
        do_req(1'b0, A_MT, 64'd0, 8'h00, ra, rb, ea, eb, acc);
        total++;
        if (ra !== exp_read(0, A_MT, acc) || rb !== exp_read(1, A_MT, acc)) begin
            bad++;
            $display("FAIL reset_mid_mtime got=%h/%h want=%h/%h", ra, rb,
                     exp_read(0, A_MT, acc), exp_read(1, A_MT, acc));
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        cnt = 0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = A_MSIP; rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (a_req_ready && req_valid) cnt++;
            step();
        end
        req_valid = 1'b0;
        if (a_rsp_valid) step();
        total++;
        if (cnt != 5) begin
            bad++;
            $display("FAIL back_to_back accepts=%0d want=5", cnt);
        end
    endtask

    task automatic test_random();
        logic [63:0] ra, rb, addr, wdata;
        logic [7:0] strb;
        logic ea, eb, wr;
        int acc, kind;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            case (kind)
                0: addr = A_MSIP;
                1: addr = A_CMP;
                2: addr = A_MT;
                default: addr = ($urandom_range(0, 1) == 0) ? BASE + 64'h8 : BASE + 64'h2_4000;
            endcase
            wdata = {$urandom, $urandom};
            if (kind == 1 || kind == 2) wdata = 64'($urandom_range(0, 60));
            strb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            do_req(wr, addr, wdata, strb, ra, rb, ea, eb, acc);
            total++;
            if ((!wr && (ra !== exp_read(0, addr, acc) || rb !== exp_read(1, addr, acc)))
                || ea !== (reg_of(addr) < 0) || eb !== (reg_of(addr) < 0)) begin
                bad++;
                $display("FAIL random_rsp k=%0d got=%h/%h err=%0b want=%h/%h err=%0b", k, ra, rb, ea,
                         exp_read(0, addr, acc), exp_read(1, addr, acc), reg_of(addr) < 0);
            end
            for (int g = $urandom_range(0, 3); g >= 0; g--) begin
                total++;
                if (a_tmr !== exp_tmr(0, cyc) || b_tmr !== exp_tmr(1, cyc)
                    || a_sw !== msip_after(cyc - 1) || b_sw !== msip_after(cyc - 1)) begin
                    bad++;
                    $display("FAIL random_irq edge=%0d got tmr=%0b%0b sw=%0b%0b want tmr=%0b%0b sw=%0b",
                             cyc, a_tmr, b_tmr, a_sw, b_sw, exp_tmr(0, cyc), exp_tmr(1, cyc),
                             msip_after(cyc - 1));
                end
                if (g > 0) step();
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_cmp_irq();
        test_wrap();
        test_div4();
        test_msip();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
